// File: rtl/muc_seq.sv
`default_nettype none
// ============================================================================
// Module      : muc_seq
// Description : Sequential sign-magnitude multiplier (iterative shift-add).
//               WIDTH-bit magnitudes with separate sign bits. Each operation
//               is framed by start / busy / done. A runtime approximate mode
//               clears the low TRUNC columns of every partial product.
//
//               Build option: define MUC_SEQ_EARLY_TERM_EN to leave RUN as
//               soon as the remaining multiplier bits are all zero. Results
//               are unchanged; only latency shrinks.
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               start      - request, sampled only in IDLE
//               a, b       - multiplicand / multiplier magnitudes
//               asign      - sign of a (1 = negative)
//               bsign      - sign of b (1 = negative)
//               approx_en  - approximate mode, sampled with start
//               busy       - high while an operation runs
//               done       - one-cycle pulse, p and sign valid
//               p          - product magnitude (2*WIDTH bits)
//               sign       - product sign (never set for a zero product)
//
// Revision    : 1.0 - initial release
// ============================================================================
module muc_seq #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 asign,
    input  logic                 bsign,
    input  logic                 approx_en,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic                 sign
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]      c_cnt_last = CW'(WIDTH);
    localparam logic [CW-1:0]      c_cnt_one  = CW'(1);
    localparam logic [2*WIDTH-1:0] c_one      = {{(2*WIDTH-1){1'b0}}, 1'b1};
    // All ones except the low TRUNC columns; TRUNC=0 yields all ones.
    localparam logic [2*WIDTH-1:0] c_trunc_mask = ~((c_one << TRUNC) - c_one);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [2*WIDTH-1:0]    r_a_shift;
    logic [WIDTH-1:0]      r_b_shift;
    logic [2*WIDTH-1:0]    r_acc;
    logic [CW-1:0]         r_cnt;
    logic                  r_asign;
    logic                  r_bsign;
    logic                  r_approx;
    logic [2*WIDTH-1:0]    r_p;
    logic                  r_sign;

    logic [2*WIDTH-1:0]    w_mask;
    logic [2*WIDTH-1:0]    w_pp;
    logic                  w_run_end;

    assign w_mask = r_approx ? c_trunc_mask : {(2*WIDTH){1'b1}};
    assign w_pp   = r_b_shift[0] ? (r_a_shift & w_mask) : '0;

    // w_run_end is evaluated at the start of a RUN cycle: when true, this
    // cycle performs no iteration and the next edge publishes the result.
`ifdef MUC_SEQ_EARLY_TERM_EN
    // The cnt != 0 term guarantees at least one iteration, so b=0 still
    // takes a single iteration before finishing.
    assign w_run_end = (r_cnt == c_cnt_last) ||
                       ((r_cnt != '0) && (r_b_shift == '0));
`else
    assign w_run_end = (r_cnt == c_cnt_last);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_run_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_asign   <= 1'b0;
            r_bsign   <= 1'b0;
            r_approx  <= 1'b0;
            r_p       <= '0;
            r_sign    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_shift <= {{WIDTH{1'b0}}, a};
                        r_b_shift <= b;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_asign   <= asign;
                        r_bsign   <= bsign;
                        r_approx  <= approx_en;
                    end
                end
                S_RUN: begin
                    if (w_run_end) begin
                        // Result registers change only on the edge into DONE
                        // and otherwise hold across later operations.
                        r_p    <= r_acc;
                        r_sign <= (r_asign ^ r_bsign) && (r_acc != '0);
                    end else begin
                        r_acc     <= r_acc + w_pp;
                        r_a_shift <= r_a_shift << 1;
                        r_b_shift <= r_b_shift >> 1;
                        r_cnt     <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign p    = r_p;
    assign sign = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_muc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muc_seq
// Description : Self-checking bench for muc_seq (WIDTH=8, TRUNC=4).
//               Table of directed operations plus hand-written handshake and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muc_seq;

    localparam int W = 8;
    localparam int T = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            asign;
    logic            bsign;
    logic            approx_en;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  p;
    logic            sign;

    int n_pass;
    int n_total;

    muc_seq #(
        .WIDTH (W),
        .TRUNC (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .asign     (asign),
        .bsign     (bsign),
        .approx_en (approx_en),
        .busy      (busy),
        .done      (done),
        .p         (p),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           asign;
        logic           bsign;
        logic           approx;
        logic [2*W-1:0] exp_p;
        logic           exp_sign;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int exp_lat(input logic [W-1:0] bb);
        int h;
        h = 0;
        for (int i = 0; i < W; i++) begin
            if (bb[i]) h = i;
        end
`ifdef MUC_SEQ_EARLY_TERM_EN
        return h + 2;
`else
        return (h >= 0) ? W + 1 : W + 1;
`endif
    endfunction

    // Drive one request; returns edges counted until done is seen (bounded).
    task automatic run_op(input vec_t v, output int lat);
        @(negedge clk);
        a = v.a; b = v.b; asign = v.asign; bsign = v.bsign; approx_en = v.approx;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs [10];

    initial begin
        int lat;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        asign = 1'b0; bsign = 1'b0; approx_en = 1'b0;

        //            a      b      as    bs    apx   p          sign
        vecs[0] = '{8'd3,   8'd1,   1'b0, 1'b1, 1'b0, 16'd3,     1'b1};
        vecs[1] = '{8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 16'hFE01,  1'b0};
        vecs[2] = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 16'hFDD0,  1'b0};
        vecs[3] = '{8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 16'hFE01,  1'b1};
        vecs[4] = '{8'd0,   8'd5,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        vecs[5] = '{8'd7,   8'd0,   1'b0, 1'b1, 1'b0, 16'd0,     1'b0};
        vecs[6] = '{8'd1,   8'h80,  1'b1, 1'b0, 1'b0, 16'd128,   1'b1};
        vecs[7] = '{8'd3,   8'd5,   1'b1, 1'b0, 1'b1, 16'd0,     1'b0};
        vecs[8] = '{8'd200, 8'd100, 1'b1, 1'b0, 1'b0, 16'd20000, 1'b1};
        vecs[9] = '{8'd15,  8'd15,  1'b0, 1'b1, 1'b1, 16'd176,   1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_p",    32'(p),    32'd0);
        check("reset_sign", 32'(sign), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].b)));
            check($sformatf("v%0d_p", i), 32'(p), 32'(vecs[i].exp_p));
            check($sformatf("v%0d_sign", i), 32'(sign), 32'(vecs[i].exp_sign));
            check($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_p_hold", i), 32'(p), 32'(vecs[i].exp_p));
        end

        // Start during RUN is ignored; the first request's result is delivered.
        @(negedge clk);
        a = 8'd9; b = 8'd11; asign = 1'b1; bsign = 1'b0; approx_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd2; b = 8'd2; asign = 1'b0; bsign = 1'b0; approx_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hs_latency", 32'(lat), 32'(exp_lat(8'd11)));
        check("hs_p",       32'(p),    32'd99);
        check("hs_sign",    32'(sign), 32'd1);
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (busy || done) seen++;
            end
            check("hs_not_queued", 32'(seen), 32'd0);
        end

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        a = 8'd5; b = 8'hFF; asign = 1'b0; bsign = 1'b0; approx_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_p",    32'(p),    32'd0);
        check("rst_mid_sign", 32'(sign), 32'd0);
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            check("rst_mid_no_done", 32'(seen), 32'd0);
        end

        begin
            vec_t v;
            v = '{8'd6, 8'd7, 1'b1, 1'b1, 1'b0, 16'd42, 1'b0};
            run_op(v, lat);
            check("post_rst_latency", 32'(lat), 32'(exp_lat(8'd7)));
            check("post_rst_p",       32'(p),    32'd42);
            check("post_rst_sign",    32'(sign), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
